// File: rtl/speed_shaper_pkg.sv
// Shared defaults for the self-balancing motor speed shaper.
package speed_shaper_pkg;
  localparam int DEF_W        = 12;
  localparam int DEF_SS_W     = 8;
  localparam int DEF_MIN_DUTY = 168;
  localparam int DEF_LOW_BAND = 42;
  localparam int DEF_GAIN     = 4;
  localparam int DEF_SLEW     = 64;
  localparam int DEF_FAST_HI  = 1536;
  localparam int DEF_FAST_LO  = 1280;

  // Per-wheel torque before shaping carries one guard bit over the speed width.
  typedef logic signed [DEF_W:0] torque_t;
endpackage

// File: rtl/speed_shaper_torque_shaper.sv
// One motor channel: deadzone compensation, saturation, slew limiting and the
// registered speed command.
module torque_shaper
  import speed_shaper_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int MIN_DUTY = DEF_MIN_DUTY,
  parameter int LOW_BAND = DEF_LOW_BAND,
  parameter int GAIN     = DEF_GAIN,
  parameter int SLEW     = DEF_SLEW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld_i,
  input  logic                zero_i,
  input  logic signed [W:0]   torque_i,
  output logic signed [W-1:0] spd_d_o,
  output logic signed [W-1:0] spd_o
);
  // Headroom so the duty offset and low-band gain never wrap before the clamp.
  localparam int XW = W + 4;
  localparam logic signed [XW-1:0] BAND_X = XW'(LOW_BAND);
  localparam logic signed [XW-1:0] DUTY_X = XW'(MIN_DUTY);
  localparam logic signed [XW-1:0] GAIN_X = XW'(GAIN);
  localparam logic signed [XW-1:0] SLEW_X = XW'(SLEW);
  localparam logic signed [XW-1:0] MAX_X  = XW'((2 ** (W - 1)) - 1);
  localparam logic signed [XW-1:0] MIN_X  = -MAX_X - XW'(1);

  logic signed [XW-1:0] t_x, dz_x, sat_x, prev_x, diff_x, step_x, nxt_x;
  logic signed [W-1:0]  spd_q, spd_d;

  // Shape the torque into a target and step the output towards it.
  always_comb begin
    t_x    = {{3{torque_i[W]}}, torque_i};
    prev_x = {{4{spd_q[W-1]}}, spd_q};
    if (t_x > BAND_X) begin
      dz_x = t_x + DUTY_X;
    end else if (t_x < -BAND_X) begin
      dz_x = t_x - DUTY_X;
    end else begin
      dz_x = t_x * GAIN_X;
    end
    if (dz_x > MAX_X) begin
      sat_x = MAX_X;
    end else if (dz_x < MIN_X) begin
      sat_x = MIN_X;
    end else begin
      sat_x = dz_x;
    end
    diff_x = sat_x - prev_x;
    if (diff_x > SLEW_X) begin
      step_x = SLEW_X;
    end else if (diff_x < -SLEW_X) begin
      step_x = -SLEW_X;
    end else begin
      step_x = diff_x;
    end
    nxt_x = prev_x + step_x;
    // Power-down zeroes the output immediately, without slewing.
    if (zero_i) begin
      spd_d = '0;
    end else if (vld_i) begin
      spd_d = W'(nxt_x);
    end else begin
      spd_d = spd_q;
    end
  end

  // Output speed register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd_q <= '0;
    end else begin
      spd_q <= spd_d;
    end
  end

  assign spd_d_o = spd_d;
  assign spd_o   = spd_q;
endmodule

// File: rtl/speed_shaper.sv
// Turns the balance controller output into left/right motor speed commands with
// soft-start, steering differential, per-channel shaping and an overspeed flag.
module speed_shaper
  import speed_shaper_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int SS_W     = DEF_SS_W,
  parameter int MIN_DUTY = DEF_MIN_DUTY,
  parameter int LOW_BAND = DEF_LOW_BAND,
  parameter int GAIN     = DEF_GAIN,
  parameter int SLEW     = DEF_SLEW,
  parameter int FAST_HI  = DEF_FAST_HI,
  parameter int FAST_LO  = DEF_FAST_LO
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] PID_cntrl,
  input  logic                vld,
  input  logic        [W-1:0] steer_pot,
  input  logic                en_steer,
  input  logic                pwr_up,
  output logic signed [W-1:0] lft_spd,
  output logic signed [W-1:0] rght_spd,
  output logic                spd_vld,
  output logic                too_fast,
  output logic                ss_done
);
  localparam int PW = SS_W + W + 1;
  localparam logic [W-1:0]        STEER_LO  = W'(2 ** (W - 3));
  localparam logic [W-1:0]        STEER_HI  = W'(7 * (2 ** (W - 3)));
  localparam logic [W-1:0]        STEER_MID = W'((2 ** (W - 1)) - 1);
  localparam logic [SS_W-1:0]     SS_ONE    = SS_W'(1);
  localparam logic signed [W-1:0] HI_S      = W'(FAST_HI);
  localparam logic signed [W-1:0] LO_S      = W'(FAST_LO);

  logic [SS_W-1:0]      ss_tmr_q, ss_tmr_d;
  logic                 ss_done_q, ss_done_d;
  logic                 s1_vld_q, s1_vld_d;
  logic signed [W:0]    lft_t_q, lft_t_d, rght_t_q, rght_t_d;
  logic                 spd_vld_q, spd_vld_d;
  logic                 too_fast_q, too_fast_d;

  logic signed [PW-1:0] prod_s;
  logic signed [W-1:0]  pid_ss_s;
  logic        [W-1:0]  steer_sat_s;
  logic signed [W:0]    offset_s, scaled_s, pid_ext_s, lft_s, rght_s;
  logic signed [W-1:0]  lft_nxt_s, rght_nxt_s;

  // Soft-start scaling and steering differential for the incoming sample.
  always_comb begin
    prod_s   = PW'($signed({1'b0, ss_tmr_q})) * PW'(PID_cntrl);
    pid_ss_s = W'(prod_s >>> SS_W);
    if (steer_pot < STEER_LO) begin
      steer_sat_s = STEER_LO;
    end else if (steer_pot > STEER_HI) begin
      steer_sat_s = STEER_HI;
    end else begin
      steer_sat_s = steer_pot;
    end
    offset_s  = $signed({1'b0, steer_sat_s}) - $signed({1'b0, STEER_MID});
    scaled_s  = (offset_s >>> 3'd3) + (offset_s >>> 3'd4);
    pid_ext_s = {pid_ss_s[W-1], pid_ss_s};
    if (en_steer) begin
      lft_s  = pid_ext_s + scaled_s;
      rght_s = pid_ext_s - scaled_s;
    end else begin
      lft_s  = pid_ext_s;
      rght_s = pid_ext_s;
    end
  end

  // Next state for the soft-start timer, stage-1 torques and status flags.
  always_comb begin
    if (!pwr_up) begin
      ss_tmr_d = '0;
    end else if (vld && (ss_tmr_q != '1)) begin
      ss_tmr_d = ss_tmr_q + SS_ONE;
    end else begin
      ss_tmr_d = ss_tmr_q;
    end
    ss_done_d = (ss_tmr_d == '1);
    s1_vld_d  = vld & pwr_up;
    if (vld) begin
      lft_t_d  = lft_s;
      rght_t_d = rght_s;
    end else begin
      lft_t_d  = lft_t_q;
      rght_t_d = rght_t_q;
    end
    spd_vld_d = s1_vld_q & pwr_up;
    // Judged on the speeds being loaded this edge, so the flag tracks spd_vld.
    if (!pwr_up) begin
      too_fast_d = 1'b0;
    end else if (s1_vld_q) begin
      if ((lft_nxt_s > HI_S) || (rght_nxt_s > HI_S)) begin
        too_fast_d = 1'b1;
      end else if ((lft_nxt_s < LO_S) && (rght_nxt_s < LO_S)) begin
        too_fast_d = 1'b0;
      end else begin
        too_fast_d = too_fast_q;
      end
    end else begin
      too_fast_d = too_fast_q;
    end
  end

  // Soft-start, stage-1 pipeline and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_tmr_q   <= '0;
      ss_done_q  <= 1'b0;
      s1_vld_q   <= 1'b0;
      lft_t_q    <= '0;
      rght_t_q   <= '0;
      spd_vld_q  <= 1'b0;
      too_fast_q <= 1'b0;
    end else begin
      ss_tmr_q   <= ss_tmr_d;
      ss_done_q  <= ss_done_d;
      s1_vld_q   <= s1_vld_d;
      lft_t_q    <= lft_t_d;
      rght_t_q   <= rght_t_d;
      spd_vld_q  <= spd_vld_d;
      too_fast_q <= too_fast_d;
    end
  end

  torque_shaper #(
    .W(W), .MIN_DUTY(MIN_DUTY), .LOW_BAND(LOW_BAND), .GAIN(GAIN), .SLEW(SLEW)
  ) u_lft (
    .clk(clk), .rst(rst), .vld_i(s1_vld_q), .zero_i(~pwr_up),
    .torque_i(lft_t_q), .spd_d_o(lft_nxt_s), .spd_o(lft_spd)
  );

  torque_shaper #(
    .W(W), .MIN_DUTY(MIN_DUTY), .LOW_BAND(LOW_BAND), .GAIN(GAIN), .SLEW(SLEW)
  ) u_rght (
    .clk(clk), .rst(rst), .vld_i(s1_vld_q), .zero_i(~pwr_up),
    .torque_i(rght_t_q), .spd_d_o(rght_nxt_s), .spd_o(rght_spd)
  );

  assign spd_vld  = spd_vld_q;
  assign too_fast = too_fast_q;
  assign ss_done  = ss_done_q;
endmodule

// File: tb/tb_speed_shaper.sv
// Self-checking bench for speed_shaper: scoreboard model plus settled-value table.
module tb_speed_shaper;
  localparam int W = 12;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [W-1:0] PID_cntrl;
  logic                vld;
  logic        [W-1:0] steer_pot;
  logic                en_steer;
  logic                pwr_up;
  logic signed [W-1:0] lft_spd;
  logic signed [W-1:0] rght_spd;
  logic                spd_vld;
  logic                too_fast;
  logic                ss_done;

  speed_shaper #(.W(W)) dut (
    .clk(clk), .rst(rst), .PID_cntrl(PID_cntrl), .vld(vld), .steer_pot(steer_pot),
    .en_steer(en_steer), .pwr_up(pwr_up), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .spd_vld(spd_vld), .too_fast(too_fast), .ss_done(ss_done)
  );

  always #5 clk = ~clk;

  typedef struct { int l; int r; bit tf; } exp_t;
  typedef struct { int pid; int pot; bit en; int exp_l; int exp_r; } vec_t;

  exp_t sb_q[$];
  vec_t vecs[11];
  int   total = 0;
  int   bad   = 0;
  int   m_tmr, m_l, m_r;
  bit   m_tf;

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int shape(input int t);
    int d;
    if (t > 42) d = t + 168;
    else if (t < -42) d = t - 168;
    else d = t * 4;
    return clampi(d, -2048, 2047);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_tmr = 0; m_l = 0; m_r = 0; m_tf = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step(input int pid, input int pot, input bit en);
    int pss, off, sc, lt, rt;
    exp_t e;
    pss = (m_tmr * pid) >>> 8;
    off = clampi(pot, 512, 3584) - 2047;
    sc  = (off >>> 3) + (off >>> 4);
    lt  = en ? pss + sc : pss;
    rt  = en ? pss - sc : pss;
    m_l = m_l + clampi(shape(lt) - m_l, -64, 64);
    m_r = m_r + clampi(shape(rt) - m_r, -64, 64);
    if (m_l > 1536 || m_r > 1536) m_tf = 1'b1;
    else if (m_l < 1280 && m_r < 1280) m_tf = 1'b0;
    if (m_tmr < 255) m_tmr++;
    e.l = m_l; e.r = m_r; e.tf = m_tf;
    sb_q.push_back(e);
  endtask

  // Entered and left at posedge+1; b2b keeps vld high into the next sample.
  task automatic drive(input int pid, input int pot, input bit en, input bit b2b);
    PID_cntrl = W'(pid);
    steer_pot = W'(pot);
    en_steer  = en;
    vld       = 1'b1;
    model_step(pid, pot, en);
    @(posedge clk); #1;
    vld = 1'b0;
    if (!b2b) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && spd_vld) begin
      if (sb_q.size() == 0) begin
        check("spd_vld_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_lft", lft_spd, e.l);
        check("sb_rght", rght_spd, e.r);
        check("sb_too_fast", int'(too_fast), int'(e.tf));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0,     32'h800, 1'b1, 0,     0};
    vecs[1]  = '{1024,  32'hE00, 1'b0, 1188,  1188};
    vecs[2]  = '{0,     32'hE00, 1'b1, 456,   -456};
    vecs[3]  = '{0,     32'h000, 1'b1, -456,  456};
    vecs[4]  = '{1024,  32'h900, 1'b1, 1236,  1140};
    vecs[5]  = '{40,    32'h800, 1'b0, 156,   156};
    vecs[6]  = '{-40,   32'h800, 1'b0, -160,  -160};
    vecs[7]  = '{43,    32'h800, 1'b0, 168,   168};
    vecs[8]  = '{44,    32'h800, 1'b0, 211,   211};
    vecs[9]  = '{-2048, 32'h800, 1'b1, -2048, -2048};
    vecs[10] = '{2047,  32'h800, 1'b1, 2047,  2047};

    rst = 1'b1; pwr_up = 1'b0; vld = 1'b0; PID_cntrl = '0; steer_pot = '0; en_steer = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_lft", lft_spd, 0);
    check("rst_rght", rght_spd, 0);
    check("rst_spd_vld", int'(spd_vld), 0);
    check("rst_too_fast", int'(too_fast), 0);
    check("rst_ss_done", int'(ss_done), 0);
    rst = 1'b0; pwr_up = 1'b1;
    @(posedge clk); #1;

    // Soft-start ramp.
    for (int i = 1; i <= 300; i++) begin
      drive(1024, 32'h800, 1'b1, 1'b0);
      if (i == 254) check("ss_done_254", int'(ss_done), 0);
      if (i == 255) check("ss_done_255", int'(ss_done), 1);
    end
    check("ramp_lft", lft_spd, 1188);
    check("ramp_rght", rght_spd, 1188);

    // Latency: spd_vld exactly two edges after the vld edge.
    PID_cntrl = W'(1024); steer_pot = W'(32'h800); en_steer = 1'b1; vld = 1'b1;
    model_step(1024, 32'h800, 1'b1);
    @(posedge clk); #1;
    vld = 1'b0;
    check("lat_edge1", int'(spd_vld), 0);
    @(posedge clk); #1;
    check("lat_edge2", int'(spd_vld), 1);
    @(posedge clk); #1;
    check("lat_edge3", int'(spd_vld), 0);

    // Step response from zero.
    for (int i = 0; i < 30; i++) drive(0, 32'h800, 1'b1, 1'b0);
    check("zero_lft", lft_spd, 0);
    for (int k = 1; k <= 3; k++) begin
      drive(1024, 32'h800, 1'b1, 1'b0);
      check("step_lft", lft_spd, 64 * k);
    end
    check("step_rght", rght_spd, 192);

    // Settled-value table.
    foreach (vecs[v]) begin
      for (int i = 0; i < 80; i++) drive(vecs[v].pid, vecs[v].pot, vecs[v].en, 1'b0);
      check($sformatf("vec%0d_lft", v), lft_spd, vecs[v].exp_l);
      check($sformatf("vec%0d_rght", v), rght_spd, vecs[v].exp_r);
    end
    check("tf_set", int'(too_fast), 1);

    // Hysteresis on the way down from full speed.
    for (int k = 1; k <= 14; k++) begin
      drive(1024, 32'h800, 1'b1, 1'b0);
      if (k == 8)  check("tf_hold_1535", int'(too_fast), 1);
      if (k == 11) check("tf_hold_1343", int'(too_fast), 1);
      if (k == 12) begin
        check("tf_lft_1279", lft_spd, 1279);
        check("tf_clear_1279", int'(too_fast), 0);
      end
    end
    check("tf_settle", lft_spd, 1188);

    // Power drop at full speed.
    for (int i = 0; i < 20; i++) drive(2047, 32'h800, 1'b1, 1'b0);
    check("pd_pre_tf", int'(too_fast), 1);
    pwr_up = 1'b0;
    @(posedge clk); #1;
    m_tmr = 0; m_l = 0; m_r = 0; m_tf = 1'b0;
    check("pd_lft", lft_spd, 0);
    check("pd_rght", rght_spd, 0);
    check("pd_too_fast", int'(too_fast), 0);
    check("pd_ss_done", int'(ss_done), 0);
    @(posedge clk); #1;
    pwr_up = 1'b1;
    @(posedge clk); #1;
    drive(1024, 32'h800, 1'b1, 1'b0);
    check("restart_tmr0", lft_spd, 0);
    for (int i = 0; i < 5; i++) drive(1024, 32'h800, 1'b1, 1'b0);

    // Back-to-back random samples.
    for (int i = 0; i < 40; i++) begin
      int p;
      p = int'($urandom_range(0, 4095));
      if (p > 2047) p = p - 4096;
      drive(p, int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("b2b_drained", sb_q.size(), 0);
    for (int i = 0; i < 5; i++) drive(1024, 32'h800, 1'b1, 1'b0);

    // Reset while a sample sits in stage 1.
    PID_cntrl = W'(2047); vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    #2 rst = 1'b1;
    model_clear();
    #4 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mrst_lft", lft_spd, 0);
    check("mrst_rght", rght_spd, 0);
    check("mrst_spd_vld", int'(spd_vld), 0);
    drive(1024, 32'h800, 1'b1, 1'b0);
    check("mrst_tmr0", lft_spd, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
